// File: rtl/arb_pkg.sv
// Shared definitions for the grant-lock arbiter slice.
//   NPORT        - number of requesters served by the arbiter
//   NO_GNT_ID    - grant index reported when nothing is granted
//   arb_state_t  - controller states: IDLE, HOLD, GAP
//   onehot_to_id - maps a one-hot grant vector to its port index
package arb_pkg;

  localparam int         NPORT     = 3;
  localparam logic [1:0] NO_GNT_ID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  // Any vector that is not exactly one-hot reports "no grant".
  function automatic logic [1:0] onehot_to_id(input logic [NPORT-1:0] oh);
    logic [1:0] id;
    case (oh)
      3'b001:  id = 2'd0;
      3'b010:  id = 2'd1;
      3'b100:  id = 2'd2;
      default: id = NO_GNT_ID;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/prio_sel3.sv
// Fixed-priority selector for three requesters.
//   req    - request vector, bit 0 has the highest priority
//   onehot - one-hot winner, all-zero when no request is present
module prio_sel3 (
  input  logic [2:0] req,
  output logic [2:0] onehot
);

  always_comb begin
    onehot = 3'b000;
    if (req[0])      onehot = 3'b001;
    else if (req[1]) onehot = 3'b010;
    else if (req[2]) onehot = 3'b100;
  end

endmodule

// File: rtl/grant_lock_ctrl.sv
// Grant-lock controller for a shared resource with three requesters.
// A winner is chosen by fixed priority, then the grant is locked until the
// resource signals done, the owner withdraws its request, or HOLD_MAX cycles
// elapse. Every release is followed by a single dead cycle before the next
// arbitration.
//   clk       - clock, rising-edge active
//   rst_n     - asynchronous active-low reset
//   req_i     - level requests, bit 0 highest priority
//   done_i    - one-cycle pulse: current transaction complete
//   gnt_o     - registered one-hot grant
//   gnt_id_o  - index of the granted port, 3 when idle
//   busy_o    - high while a grant is held
//   timeout_o - one-cycle pulse on forced release at HOLD_MAX
module grant_lock_ctrl
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] req_i,
  input  logic             done_i,
  output logic [NPORT-1:0] gnt_o,
  output logic [1:0]       gnt_id_o,
  output logic             busy_o,
  output logic             timeout_o
);

  // The counter starts at 0 on the first held cycle, so the last permitted
  // cycle is the one where it reads HOLD_MAX-1.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  arb_state_t       state, state_nxt;
  logic [7:0]       hold_cnt, hold_cnt_nxt;
  logic [NPORT-1:0] gnt_nxt;
  logic             timeout_nxt;
  logic [NPORT-1:0] winner;
  logic             withdraw;
  logic             expire;

  prio_sel3 u_prio_sel3 (
    .req    (req_i),
    .onehot (winner)
  );

  assign withdraw = ~|(req_i & gnt_o);
  assign expire   = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt_o;
    hold_cnt_nxt = hold_cnt;
    timeout_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        gnt_nxt      = 3'b000;
        hold_cnt_nxt = 8'd0;
        if (|req_i) begin
          gnt_nxt   = winner;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // done has precedence over both withdrawal and expiry; withdrawal
        // also suppresses the timeout pulse.
        if (done_i || withdraw) begin
          gnt_nxt      = 3'b000;
          hold_cnt_nxt = 8'd0;
          state_nxt    = ST_GAP;
        end else if (expire) begin
          gnt_nxt      = 3'b000;
          hold_cnt_nxt = 8'd0;
          timeout_nxt  = 1'b1;
          state_nxt    = ST_GAP;
        end else begin
          hold_cnt_nxt = hold_cnt + 8'd1;
        end
      end
      ST_GAP: begin
        gnt_nxt      = 3'b000;
        hold_cnt_nxt = 8'd0;
        state_nxt    = ST_IDLE;
      end
      default: begin
        gnt_nxt      = 3'b000;
        hold_cnt_nxt = 8'd0;
        state_nxt    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt_o     <= 3'b000;
      hold_cnt  <= 8'd0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt_o     <= gnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
      timeout_o <= timeout_nxt;
    end
  end

  assign busy_o   = (state == ST_HOLD);
  assign gnt_id_o = onehot_to_id(gnt_o);

endmodule

// File: tb/tb_grant_lock_ctrl.sv
module tb_grant_lock_ctrl;

  localparam int HMAX = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req_i;
  logic       done_i;
  logic [2:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       busy_o;
  logic       timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  grant_lock_ctrl #(.HOLD_MAX(HMAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .done_i    (done_i),
    .gnt_o     (gnt_o),
    .gnt_id_o  (gnt_id_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the resource, for how many cycles it has
  // been visible, whether we are in the dead cycle after a release, and
  // whether the last release was forced.
  int owner = -1;
  int held  = 0;
  bit in_gap = 1'b0;
  bit m_tmo  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner  = -1;
      held   = 0;
      in_gap = 1'b0;
      m_tmo  = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (owner >= 0) begin
        if (done_i || !req_i[owner]) begin
          owner  = -1;
          in_gap = 1'b1;
        end else if (held == HMAX) begin
          owner  = -1;
          in_gap = 1'b1;
          m_tmo  = 1'b1;
        end else begin
          held = held + 1;
        end
      end else if (in_gap) begin
        in_gap = 1'b0;
      end else if (req_i != 3'b000) begin
        for (int p = 2; p >= 0; p--)
          if (req_i[p]) owner = p;
        held = 1;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] e_gnt;
    logic [1:0] e_id;
    e_gnt = (owner >= 0) ? 3'(1 << owner) : 3'b000;
    e_id  = (owner >= 0) ? 2'(owner) : 2'd3;
    check("cyc_gnt",  8'(gnt_o),     8'(e_gnt));
    check("cyc_id",   8'(gnt_id_o),  8'(e_id));
    check("cyc_busy", 8'(busy_o),    8'(owner >= 0));
    check("cyc_tmo",  8'(timeout_o), 8'(m_tmo));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [2:0] req; logic done; } vec_t;
  vec_t vecs[16];

  initial begin
    rst_n  = 1'b0;
    req_i  = 3'b000;
    done_i = 1'b0;
    #1;
    check("rst_gnt",  8'(gnt_o),     8'h0);
    check("rst_id",   8'(gnt_id_o),  8'h3);
    check("rst_busy", 8'(busy_o),    8'h0);
    check("rst_tmo",  8'(timeout_o), 8'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Middle-priority winner from idle
    req_i = 3'b110;
    tick();
    check("a_gnt",  8'(gnt_o),    8'h2);
    check("a_id",   8'(gnt_id_o), 8'h1);
    check("a_busy", 8'(busy_o),   8'h1);
    done_i = 1'b1; req_i = 3'b000;
    tick();
    done_i = 1'b0;
    check("a_gap", 8'(gnt_o), 8'h0);
    tick();

    // No preemption during hold
    req_i = 3'b100;
    tick();
    check("b_gnt", 8'(gnt_o), 8'h4);
    req_i = 3'b111;
    tick();
    check("b_lock", 8'(gnt_o), 8'h4);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("b_gap",  8'(gnt_o),  8'h0);
    check("b_gapb", 8'(busy_o), 8'h0);
    tick();
    check("b_idle", 8'(gnt_o), 8'h0);
    tick();
    check("b_regnt", 8'(gnt_o), 8'h1);

    // Withdrawal by owner, then done ignored in idle
    req_i = 3'b110;
    tick();
    check("c_gnt", 8'(gnt_o),     8'h0);
    check("c_tmo", 8'(timeout_o), 8'h0);
    req_i = 3'b000;
    tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("c_idle_done", 8'(busy_o), 8'h0);
    tick();
    check("c_idle_gnt", 8'(gnt_o), 8'h0);

    // Forced release after HOLD_MAX cycles
    req_i = 3'b001;
    for (int i = 0; i < HMAX; i++) begin
      tick();
      check("d_held", 8'(gnt_o), 8'h1);
    end
    tick();
    check("d_rel", 8'(gnt_o),     8'h0);
    check("d_tmo", 8'(timeout_o), 8'h1);
    tick();
    check("d_tmo_end", 8'(timeout_o), 8'h0);
    tick();
    check("d_regnt", 8'(gnt_o), 8'h1);

    // done on the expiry cycle wins over the timeout
    tick(); tick(); tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("e_rel", 8'(gnt_o),     8'h0);
    check("e_tmo", 8'(timeout_o), 8'h0);
    req_i = 3'b000;
    tick();
    check("e_tmo2", 8'(timeout_o), 8'h0);
    tick();

    // Asynchronous reset in the middle of a hold
    req_i = 3'b010;
    tick();
    check("f_gnt", 8'(gnt_o), 8'h2);
    #1;
    rst_n = 1'b0;
    #1;
    check("f_rst_gnt", 8'(gnt_o),     8'h0);
    check("f_rst_id",  8'(gnt_id_o),  8'h3);
    check("f_rst_tmo", 8'(timeout_o), 8'h0);
    req_i = 3'b100;
    tick();
    rst_n = 1'b1;
    check("f_still", 8'(gnt_o), 8'h0);
    tick();
    check("f_regnt", 8'(gnt_o), 8'h4);
    req_i = 3'b000;
    tick(); tick();

    // Mixed sequence checked by the model only, including simultaneous
    // done+withdraw and withdraw on the expiry cycle
    vecs = '{
      '{3'b011, 1'b0}, '{3'b011, 1'b0}, '{3'b010, 1'b1}, '{3'b010, 1'b0},
      '{3'b010, 1'b0}, '{3'b010, 1'b0}, '{3'b010, 1'b0}, '{3'b100, 1'b0},
      '{3'b100, 1'b0}, '{3'b101, 1'b0}, '{3'b101, 1'b0}, '{3'b101, 1'b0},
      '{3'b101, 1'b0}, '{3'b100, 1'b0}, '{3'b000, 1'b1}, '{3'b000, 1'b0}
    };
    foreach (vecs[i]) begin
      req_i  = vecs[i].req;
      done_i = vecs[i].done;
      tick();
    end
    req_i  = 3'b000;
    done_i = 1'b0;
    tick(); tick();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
